// File: rtl/sn74161_if.sv
// Signal bundle for the SN74161 counter: chip clock, load/enable controls,
// parallel data in, counter and ripple-carry outputs.
interface sn74161_if;
    logic CLK;
    logic LOAD_N;
    logic ENP;
    logic ENT;
    logic A;
    logic B;
    logic C;
    logic D;
    logic QA;
    logic QB;
    logic QC;
    logic QD;
    logic RCO;

    modport master (
        output CLK, LOAD_N, ENP, ENT, A, B, C, D,
        input  QA, QB, QC, QD, RCO
    );

    modport slave (
        input  CLK, LOAD_N, ENP, ENT, A, B, C, D,
        output QA, QB, QC, QD, RCO
    );
endinterface

// File: rtl/sn74161.sv
// SN74161 4-bit synchronous binary counter rebuilt on a fast drive clock;
// the chip CLK is sampled as data and its rising edge is the count/load event.
module sn74161 #(
    parameter int SYNC_STAGES = 0
) (
    input  logic        CLK_DRV,
    input  logic        CLR_N,
    sn74161_if.slave    bus
);

    logic       clk_sync;
    logic       clk_prev_reg;
    logic       clk_edge;
    logic [3:0] q_reg;
    logic [3:0] q_next;

    // The CLK sampling path keeps tracking CLK while CLR_N is low, so a CLK
    // already high at clear release is not mistaken for a fresh rising edge.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign clk_sync = bus.CLK;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] stage_reg;

            always_ff @(posedge CLK_DRV) begin
                stage_reg[0] <= bus.CLK;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    stage_reg[i] <= stage_reg[i-1];
                end
            end

            assign clk_sync = stage_reg[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge CLK_DRV) begin
        clk_prev_reg <= clk_sync;
    end

    assign clk_edge = clk_sync & ~clk_prev_reg;

    always_comb begin
        q_next = q_reg;
        if (clk_edge) begin
            if (!bus.LOAD_N) begin
                q_next = {bus.D, bus.C, bus.B, bus.A};
            end else if (bus.ENP && bus.ENT) begin
                q_next = q_reg + 4'd1;
            end
        end
    end

    // Clear wins over a coincident edge; that edge is simply dropped.
    always_ff @(posedge CLK_DRV) begin
        if (!CLR_N) begin
            q_reg <= 4'b0000;
        end else begin
            q_reg <= q_next;
        end
    end

    assign bus.QA  = q_reg[0];
    assign bus.QB  = q_reg[1];
    assign bus.QC  = q_reg[2];
    assign bus.QD  = q_reg[3];
    assign bus.RCO = bus.ENT & (&q_reg);

endmodule
